// File: rtl/rv32i_core_pkg.sv
// Shared RV32I core types: datapath width, ALU opcodes,
// ALU request/response bundles and response-buffer state.
package rv32i_core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    alu_op_e         alu_op;
  } alu_req_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
  } alu_rsp_t;

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_e;

endpackage

// File: rtl/rv32i_alu_arbiter_if.sv
// Request/response bundle between NUM_REQ ALU requesters
// and the shared-ALU arbiter.
// master: requesters + response consumer; slave: arbiter.
interface rv32i_alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN_P  = rv32i_core_pkg::XLEN,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();
  import rv32i_core_pkg::*;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][XLEN_P-1:0] req_op_a_i;
  logic [NUM_REQ-1:0][XLEN_P-1:0] req_op_b_i;
  alu_op_e [NUM_REQ-1:0]          req_alu_op_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [ID_W-1:0]   rsp_id_o;
  logic [XLEN_P-1:0] rsp_result_o;
  logic              rsp_cmp_eq_o;
  logic              rsp_cmp_lt_o;
  logic              rsp_cmp_ltu_o;

  modport master (
    output req_valid_i, req_op_a_i,
    output req_op_b_i, req_alu_op_i,
    input  req_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_id_o,
    input  rsp_result_o, rsp_cmp_eq_o,
    input  rsp_cmp_lt_o, rsp_cmp_ltu_o
  );

  modport slave (
    input  req_valid_i, req_op_a_i,
    input  req_op_b_i, req_alu_op_i,
    output req_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_id_o,
    output rsp_result_o, rsp_cmp_eq_o,
    output rsp_cmp_lt_o, rsp_cmp_ltu_o
  );

endinterface

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU with compare flags.
// Ports: op_a_i/op_b_i/alu_op_i in; result_o, cmp_*_o out.
module rv32i_alu
  import rv32i_core_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN
) (
  input  logic [XLEN_P-1:0] op_a_i,
  input  logic [XLEN_P-1:0] op_b_i,
  input  alu_op_e           alu_op_i,
  output logic [XLEN_P-1:0] result_o,
  output logic              cmp_eq_o,
  output logic              cmp_lt_o,
  output logic              cmp_ltu_o
);

  localparam int unsigned SH_W = $clog2(XLEN_P);

  logic [SH_W-1:0] shamt;

  assign shamt     = op_b_i[SH_W-1:0];
  assign cmp_eq_o  = (op_a_i == op_b_i);
  assign cmp_lt_o  = ($signed(op_a_i) < $signed(op_b_i));
  assign cmp_ltu_o = (op_a_i < op_b_i);

  always_comb begin
    result_o = '0;
    unique case (alu_op_i)
      ALU_ADD:  result_o = op_a_i + op_b_i;
      ALU_SUB:  result_o = op_a_i - op_b_i;
      ALU_SLL:  result_o = op_a_i << shamt;
      ALU_SLT:  result_o = XLEN_P'(cmp_lt_o);
      ALU_SLTU: result_o = XLEN_P'(cmp_ltu_o);
      ALU_XOR:  result_o = op_a_i ^ op_b_i;
      ALU_SRL:  result_o = op_a_i >> shamt;
      ALU_SRA:  result_o = XLEN_P'($signed(op_a_i) >>> shamt);
      ALU_OR:   result_o = op_a_i | op_b_i;
      ALU_AND:  result_o = op_a_i & op_b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Round-robin share of one ALU among NUM_REQ requesters,
// result held in a one-entry response buffer with backpressure.
// Ports: clk_i, rst_ni (sync, active-low), flush_i, bus (slave).
module rv32i_alu_arbiter
  import rv32i_core_pkg::*;
#(
  parameter int unsigned XLEN_P  = XLEN,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  rv32i_alu_arbiter_if.slave bus
);

  rsp_state_e         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_id;
  alu_rsp_t           rsp_q;
  alu_rsp_t           alu_rsp;
  alu_req_t           sel_req;
  logic [NUM_REQ-1:0] grant;
  logic               free;

  logic [XLEN_P-1:0]  alu_res;
  logic               alu_eq;
  logic               alu_lt;
  logic               alu_ltu;

  // Distance from the pointer ranks each requester; the
  // closest valid one (wrapping) wins.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [ID_W-1:0]    p
  );
    logic [NUM_REQ-1:0] g;
    int best;
    int d;
    g    = '0;
    best = int'(NUM_REQ);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      d = (i + int'(NUM_REQ) - int'(p)) % int'(NUM_REQ);
      if (v[i] && d < best) best = d;
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      d = (i + int'(NUM_REQ) - int'(p)) % int'(NUM_REQ);
      g[i] = v[i] && (d == best);
    end
    return g;
  endfunction

  always_comb begin
    free  = (state_q == RSP_EMPTY) || bus.rsp_ready_i;
    grant = '0;
    if (rst_ni && free && !flush_i) begin
      grant = rr_pick(bus.req_valid_i, ptr_q);
    end
  end

  always_comb begin
    sel_req = '0;
    win_id  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_req.op_a   = bus.req_op_a_i[i];
        sel_req.op_b   = bus.req_op_b_i[i];
        sel_req.alu_op = bus.req_alu_op_i[i];
        win_id         = ID_W'(i);
      end
    end
    ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ?
            '0 : win_id + 1'b1;
  end

  rv32i_alu #(
    .XLEN_P (XLEN_P)
  ) u_alu (
    .op_a_i    (sel_req.op_a),
    .op_b_i    (sel_req.op_b),
    .alu_op_i  (sel_req.alu_op),
    .result_o  (alu_res),
    .cmp_eq_o  (alu_eq),
    .cmp_lt_o  (alu_lt),
    .cmp_ltu_o (alu_ltu)
  );

  always_comb begin
    alu_rsp.result  = alu_res;
    alu_rsp.cmp_eq  = alu_eq;
    alu_rsp.cmp_lt  = alu_lt;
    alu_rsp.cmp_ltu = alu_ltu;
  end

  // Flush wins over everything; a grant refills even while
  // the old response drains in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RSP_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      rsp_q   <= '0;
    end else if (flush_i) begin
      state_q <= RSP_EMPTY;
    end else if (|grant) begin
      state_q <= RSP_FULL;
      rsp_q   <= alu_rsp;
      id_q    <= win_id;
      ptr_q   <= ptr_d;
    end else if (bus.rsp_ready_i) begin
      state_q <= RSP_EMPTY;
    end
  end

  assign bus.req_ready_o   = grant;
  assign bus.rsp_valid_o   = (state_q == RSP_FULL);
  assign bus.rsp_id_o      = id_q;
  assign bus.rsp_result_o  = rsp_q.result;
  assign bus.rsp_cmp_eq_o  = rsp_q.cmp_eq;
  assign bus.rsp_cmp_lt_o  = rsp_q.cmp_lt;
  assign bus.rsp_cmp_ltu_o = rsp_q.cmp_ltu;

endmodule

// File: doc/rv32i_alu_arbiter.md
Name: rv32i_alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one rv32i_alu instance between NUM_REQ requesters, for example the execute stage and the branch/address unit.
- Each requester presents operands and an operation code through a valid/ready handshake.
- The granted request is evaluated by the ALU and captured into a one-entry response register.
- The response is returned with the winner's ID on a single response channel that supports backpressure.

Parameters:
XLEN_P, XLEN, datapath width (passed to rv32i_alu).
NUM_REQ, 2, number of requesters (≥2).
ID_W, $clog2(NUM_REQ), width of the response tag.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, synchronous, active-low.
flush_i  input  1  synchronous discard of the buffered response.
req_valid_i  input  NUM_REQ  per-requester request valid.
req_ready_o  output  NUM_REQ  per-requester accept (one-hot or zero).
req_op_a_i  input  NUM_REQ x XLEN_P  operand A per requester.
req_op_b_i  input  NUM_REQ x XLEN_P  operand B per requester.
req_alu_op_i  input  NUM_REQ x alu_op_e  operation per requester.
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  response consumer ready.
rsp_id_o  output  ID_W  index of the requester that owns the response.
rsp_result_o  output  XLEN_P  ALU result.
rsp_cmp_eq_o / rsp_cmp_lt_o / rsp_cmp_ltu_o  output  1 each  ALU compare flags.

Behaviour:
- Reset: one clock with rst_ni=0, applied at a clock edge.
  - rsp_valid_o=0; rsp_id_o, rsp_result_o and cmp flags = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready_o is 0 while rst_ni=0.
- Reset mid-operation drops any buffered response; there is no partial state.
- Buffer free condition: free = !rsp_valid_o || rsp_ready_i.
- Grant:
  - When free and !flush_i, grant the first valid requester found scanning from the pointer upward, wrapping modulo NUM_REQ.
  - req_ready_o[i] = grant[i]. It is combinational from req_valid_i, the pointer, the buffer state and flush_i.
  - At most one bit is set per cycle.
- Requester rule: once req_valid_i[i]=1, valid and payload hold stable until req_ready_o[i]=1. The arbiter does not check this.
- Accept: the handshake is valid & ready in cycle N.
  - The ALU evaluates the winner's operands combinationally.
  - Result, flags and ID are registered at the end of cycle N.
  - rsp_valid_o=1 in cycle N+1, so latency is exactly 1 cycle.
- Pointer update: on a grant to i, pointer ← (i+1) mod NUM_REQ. With no grant the pointer holds.
  - Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
- Backpressure:
  - rsp_valid_o=1 with rsp_ready_i=0 holds all rsp_* stable, and no grant is issued.
  - rsp_valid_o=1 with rsp_ready_i=1 in the same cycle as a new grant is full throughput: the buffer is overwritten and rsp_valid_o stays 1.
- Drain without refill: rsp_ready_i=1 with no grant gives rsp_valid_o=0 next cycle.
- flush_i=1:
  - No grant that cycle.
  - rsp_valid_o=0 next cycle, even if rsp_ready_i=0.
  - The pointer holds.
  - flush_i has priority over the handshake.
- Payload registers update only on accept; their values are don't-care while rsp_valid_o=0.
- State machine (implicit in rsp_valid_o): EMPTY → FULL on grant; FULL → FULL on drain+grant or stall; FULL → EMPTY on drain without grant, or on flush.
- Widths: results are XLEN_P wide. Shift amount is taken from operand_b[$clog2(XLEN_P)-1:0] inside the ALU. ID width is ID_W.

Decomposition:
- rv32i_core_pkg already supplies alu_op_e and XLEN.
- Add to the package:
  - alu_req_t, a packed struct {op_a, op_b, alu_op}.
  - alu_rsp_t, a packed struct {result, cmp_eq, cmp_lt, cmp_ltu}.
- Sub-module: one rv32i_alu instance fed by the grant mux.
- The round-robin priority pick is a function inside this module, not a separate module.

Test Plan:
- Reset, then single request: req0 ADD 5+7 in cycle N → req_ready_o=01 in N; in N+1 rsp_valid_o=1, rsp_id_o=0, result=12, cmp_lt=1.
- Both requesters valid continuously: req0 SUB 10-3, req1 SLTU 1<0xFFFFFFFF, rsp_ready_i=1 → grants alternate 0,1,0,1 from reset; results 7 and 1 arrive back-to-back; one response per cycle.
- Backpressure: rsp_ready_i=0 for 3 cycles with rsp holding SRA 0x80000000>>>4 → rsp_result_o=0xF8000000 stays stable; req_ready_o=00 throughout; resumes the cycle rsp_ready_i=1.
- Flush: rsp_valid_o=1, rsp_ready_i=0, flush_i=1 with req1 valid → no grant that cycle; rsp_valid_o=0 next; req1 granted the following cycle.
- Reset mid-operation: rst_ni=0 for one cycle while rsp_valid_o=1 and both requesters valid → rsp_valid_o=0, pointer=0; first post-reset grant goes to req0.
- Wrap-around with NUM_REQ=3: only req2 valid, then req0 and req1 valid → grant order 2, 0, 1.
